// File: rtl/fifo_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter_pkg
// Description : Shared FIFO-element definitions. Holds the arbiter state
//               encoding, the default burst timeout and a wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_write_arbiter_pkg;

    // Two-state burst arbiter: no owner / owner locked
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Default number of idle burst cycles tolerated before revoking a grant
    localparam int c_default_timeout = 15;

    // Idle counter width; covers the full legal timeout range 1..255
    localparam int c_idle_cnt_w = 8;

    // Next index after value, wrapping modulo modulus
    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1) % modulus;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin select. Returns the first asserted
//               request at or after ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        logic [PW-1:0] k;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = PW'((int'(ptr) + i) % N);
            if (req[k]) begin
                idx = k;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Burst-locking round-robin arbiter for N requesters sharing a
//               single FIFO write port, with idle-timeout grant revocation.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = c_default_timeout
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    input  logic [N*WIDTH-1:0]   data,
    input  logic                 fifo_full,
    output logic [N-1:0]         ack,
    output logic                 fifo_wr,
    output logic [WIDTH-1:0]     fifo_data,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 abort
);

    localparam int PW = $clog2(N);

    arb_state_e              state_q, state_d;
    logic [PW-1:0]           owner_q, owner_d;
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [c_idle_cnt_w-1:0] idle_cnt_q, idle_cnt_d;
    logic                    abort_q, abort_d;

    logic [PW-1:0]           w_pick_idx;
    logic                    w_pick_any;
    logic                    w_owner_req;
    logic                    w_owner_last;
    logic                    w_xfer;
    logic                    w_timeout;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Owner strobes, transfer qualifier and timeout detect
    always_comb begin
        w_owner_req  = req[owner_q];
        w_owner_last = last[owner_q];
        w_xfer       = (state_q == ST_BURST) && w_owner_req && !fifo_full;
        w_timeout    = (int'(idle_cnt_q) + 1) >= TIMEOUT;
    end

    // Route the owner's word and ack; only the owner can ever be acked
    always_comb begin
        ack       = '0;
        fifo_data = '0;
        for (int k = 0; k < N; k++) begin
            if (owner_q == PW'(k)) begin
                ack[k]    = w_xfer;
                fifo_data = data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_wr = w_xfer;
    assign busy    = (state_q == ST_BURST);
    assign owner   = owner_q;
    assign abort   = abort_q;

    // Next-state logic: arbitrate in IDLE, track burst end / idle timeout in BURST
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        abort_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    state_d    = ST_BURST;
                    owner_d    = w_pick_idx;
                    idle_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (w_xfer) begin
                    // A transfer always wins over a coincident timeout
                    idle_cnt_d = '0;
                    if (w_owner_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = PW'(wrap_inc(int'(owner_q), N));
                    end
                end else if (!w_owner_req) begin
                    // Owner has nothing to send; a full-FIFO stall is not idle time
                    if (w_timeout) begin
                        state_d    = ST_IDLE;
                        rr_ptr_d   = PW'(wrap_inc(int'(owner_q), N));
                        idle_cnt_d = '0;
                        abort_d    = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            abort_q    <= abort_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Self-checking bench for fifo_write_arbiter: vector table,
//               directed corner sequences and randomized traffic compared
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     last;
    logic [N*W-1:0]   data;
    logic             fifo_full;
    logic [N-1:0]     ack;
    logic             fifo_wr;
    logic [W-1:0]     fifo_data;
    logic             busy;
    logic [1:0]       owner;
    logic             abort;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: who holds the port, where the next search starts,
    // how long the owner has been silent, and whether a revoke just happened
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_idle;
    bit m_abort;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .N       (N),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .data      (data),
        .fifo_full (fifo_full),
        .ack       (ack),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .busy      (busy),
        .owner     (owner),
        .abort     (abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_idle  = 0;
        m_abort = 1'b0;
    endtask

    function automatic bit m_xfer();
        return m_busy && req[m_owner] && !fifo_full;
    endfunction

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit x;
        int k;
        if (!rst_n) begin
            model_reset();
            return;
        end
        x       = m_xfer();
        m_abort = 1'b0;
        if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (!m_busy && req[k]) begin
                    m_busy  = 1'b1;
                    m_owner = k;
                    m_idle  = 0;
                end
            end
        end else if (x) begin
            m_idle = 0;
            if (last[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else if (!req[m_owner]) begin
            m_idle++;
            if (m_idle >= TO) begin
                m_busy  = 1'b0;
                m_ptr   = (m_owner + 1) % N;
                m_abort = 1'b1;
                m_idle  = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare every output against the model (call at the falling edge)
    task automatic cmp_model(input string tag);
        logic [N-1:0] e_ack;
        e_ack = '0;
        if (m_xfer()) e_ack[m_owner] = 1'b1;
        check({tag, "_ack"},   ack,     e_ack);
        check({tag, "_wr"},    fifo_wr, |e_ack);
        check({tag, "_busy"},  busy,    m_busy);
        check({tag, "_abort"}, abort,   m_abort);
        if (m_busy) check({tag, "_owner"}, owner, m_owner);
        if (|e_ack) check({tag, "_data"}, fifo_data, data[m_owner*W +: W]);
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [N-1:0]   last;
        logic [N*W-1:0] data;
        logic           full;
        logic [N-1:0]   e_ack;
        logic           e_busy;
        logic [W-1:0]   e_data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single 3-word burst by requester 2, then a contested grant showing ptr=3
        vecs[0] = '{4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[1] = '{4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 4'b0100, 1'b1, 8'hA1};
        vecs[2] = '{4'b0100, 4'b0000, 32'h00A2_0000, 1'b0, 4'b0100, 1'b1, 8'hA2};
        vecs[3] = '{4'b0100, 4'b0100, 32'h00A3_0000, 1'b0, 4'b0100, 1'b1, 8'hA3};
        vecs[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[5] = '{4'b1111, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[6] = '{4'b1111, 4'b1111, 32'h4433_2211, 1'b0, 4'b1000, 1'b1, 8'h44};
        vecs[7] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'h00};

        // Reset state
        rst_n = 1'b0; req = '0; last = '0; data = '0; fifo_full = 1'b0;
        model_reset();
        tick();
        tick();
        @(negedge clk);
        check("rst_ack", ack, 4'b0000);
        check("rst_wr", fifo_wr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_abort", abort, 1'b0);
        tick();
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req; last = vecs[i].last; data = vecs[i].data; fifo_full = vecs[i].full;
            @(negedge clk);
            check($sformatf("vec%0d_ack", i), ack, vecs[i].e_ack);
            check($sformatf("vec%0d_wr", i), fifo_wr, |vecs[i].e_ack);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            if (|vecs[i].e_ack) check($sformatf("vec%0d_data", i), fifo_data, vecs[i].e_data);
            tick();
        end

        // Round-robin with all requesting, one-word bursts: 0,1,2,3,0 with IDLE gaps
        req = 4'b1111; last = 4'b1111; data = 32'h4433_2211;
        for (int i = 0; i < 10; i++) begin
            logic [N-1:0] e;
            e = '0;
            if (i % 2 == 1) e[(i / 2) % N] = 1'b1;
            @(negedge clk);
            check($sformatf("rr%0d_ack", i), ack, e);
            check($sformatf("rr%0d_busy", i), busy, i % 2);
            if (i % 2 == 1) check($sformatf("rr%0d_data", i), fifo_data, 8'h11 * ((i / 2) % N + 1));
            tick();
        end
        req = '0; last = '0;
        @(negedge clk);
        check("rr_end_busy", busy, 1'b0);
        tick();

        // Backpressure: long full stall with owner requesting neither acks nor aborts
        req = 4'b0010; last = '0; data = 32'h0000_5500;
        @(negedge clk);
        check("bp_arb_ack", ack, 4'b0000);
        tick();
        @(negedge clk);
        check("bp_first_ack", ack, 4'b0010);
        check("bp_first_data", fifo_data, 8'h55);
        tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("bp_stall%0d_ack", i), ack, 4'b0000);
            check($sformatf("bp_stall%0d_wr", i), fifo_wr, 1'b0);
            check($sformatf("bp_stall%0d_abort", i), abort, 1'b0);
            check($sformatf("bp_stall%0d_busy", i), busy, 1'b1);
            tick();
        end
        fifo_full = 1'b0; last = 4'b0010; data = 32'h0000_6600;
        @(negedge clk);
        check("bp_resume_ack", ack, 4'b0010);
        check("bp_resume_data", fifo_data, 8'h66);
        tick();
        req = '0; last = '0;
        @(negedge clk);
        check("bp_end_busy", busy, 1'b0);
        tick();

        // Timeout: owner 1 sends one word then goes silent while requester 2 waits
        req = 4'b0010; last = '0; data = 32'h0000_7700;
        @(negedge clk);
        check("to_arb_busy", busy, 1'b0);
        tick();
        @(negedge clk);
        check("to_word_ack", ack, 4'b0010);
        tick();
        req = 4'b0100; data = 32'h0088_7700;
        for (int t = 1; t <= 15; t++) begin
            @(negedge clk);
            check($sformatf("to_t%0d_abort", t), abort, 1'b0);
            check($sformatf("to_t%0d_busy", t), busy, 1'b1);
            check($sformatf("to_t%0d_ack", t), ack, 4'b0000);
            tick();
        end
        @(negedge clk);
        check("to_t16_abort", abort, 1'b1);
        check("to_t16_busy", busy, 1'b0);
        tick();
        last = 4'b0100;
        @(negedge clk);
        check("to_t17_abort", abort, 1'b0);
        check("to_t17_owner", owner, 2'd2);
        check("to_t17_ack", ack, 4'b0100);
        check("to_t17_data", fifo_data, 8'h88);
        tick();
        req = '0; last = '0;
        @(negedge clk);
        check("to_end_busy", busy, 1'b0);
        tick();

        // Reset mid-burst by owner 3
        req = 4'b1000; last = '0; data = 32'h9900_0000;
        @(negedge clk);
        check("rm_arb_busy", busy, 1'b0);
        tick();
        @(negedge clk);
        check("rm_word_ack", ack, 4'b1000);
        check("rm_word_owner", owner, 2'd3);
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rm_imm_ack", ack, 4'b0000);
        check("rm_imm_busy", busy, 1'b0);
        check("rm_imm_wr", fifo_wr, 1'b0);
        tick();
        @(negedge clk);
        check("rm_hold_ack", ack, 4'b0000);
        check("rm_hold_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1; req = 4'b1001; data = 32'h9900_00C0;
        @(negedge clk);
        check("rm_rel_busy", busy, 1'b0);
        check("rm_rel_ack", ack, 4'b0000);
        tick();
        last = 4'b0001;
        @(negedge clk);
        check("rm_grant_owner", owner, 2'd0);
        check("rm_grant_ack", ack, 4'b0001);
        check("rm_grant_data", fifo_data, 8'hC0);
        tick();

        // Randomized traffic against the model; sparse segments provoke timeouts
        for (int c = 0; c < 400; c++) begin
            bit sparse;
            sparse = ((c / 50) % 2) == 1;
            for (int k = 0; k < N; k++) begin
                req[k]  = sparse ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
                last[k] = ($urandom_range(0, 3) == 0);
            end
            data      = $urandom;
            fifo_full = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            cmp_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one FIFO write port; legal range 2..8.
REQ-002 Parameter WIDTH, default 8: FIFO data word width in bits.
REQ-003 Parameter TIMEOUT, default 15: maximum number of idle cycles within a burst before the grant is revoked; legal range 1..255.
REQ-004 clk  input  1  single system clock; all state changes occur on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  N  per-requester "word available" strobe.
REQ-007 last  input  N  per-requester flag marking its current word as the final word of its burst.
REQ-008 data  input  N*WIDTH  per-requester words; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-009 fifo_full  input  1  the downstream FIFO cannot accept a word this cycle.
REQ-010 ack  output  N  one-hot (or zero); ack[k] high means requester k's word is written this cycle.
REQ-011 fifo_wr  output  1  write strobe to the FIFO.
REQ-012 fifo_data  output  WIDTH  word written to the FIFO.
REQ-013 busy  output  1  a burst owner is currently locked.
REQ-014 owner  output  clog2(N)  index of the locked requester; valid only while busy is high.
REQ-015 abort  output  1  one-cycle pulse when a burst is revoked by timeout.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE (no owner) and BURST (owner locked).
REQ-017 In IDLE with req != 0, the block SHALL select the first requester at or after rr_ptr (wrapping modulo N), latch it as owner, and enter BURST on the next edge; arbitration latency is 1 cycle.
REQ-018 In IDLE, ack SHALL be 0 and fifo_wr SHALL be 0; no word is transferred in the arbitration cycle.
REQ-019 In BURST, ack[owner] and fifo_wr SHALL be asserted combinationally when req[owner]=1 and fifo_full=0; fifo_data SHALL equal data[owner] whenever fifo_wr=1.
REQ-020 ack SHALL never be asserted for a non-owner, and fifo_wr SHALL equal the OR of ack.
REQ-021 A transfer with last[owner]=1 SHALL end the burst: next state IDLE, rr_ptr <= (owner+1) mod N.
REQ-022 An idle counter SHALL clear on every transfer and on entry to BURST, and SHALL increment on each BURST cycle with no transfer; a stall caused by fifo_full with req[owner]=1 SHALL NOT increment it.
REQ-023 When the idle counter reaches TIMEOUT, the block SHALL return to IDLE, set rr_ptr <= (owner+1) mod N, and pulse abort for exactly that one cycle.
REQ-024 When a transfer and the timeout condition occur in the same cycle, the transfer SHALL take priority and the counter SHALL clear.
REQ-025 Requests from non-owners during BURST SHALL be held pending and considered only at the next IDLE arbitration.
REQ-026 When requester k is the sole requester, it SHALL be re-granted after each burst, with one IDLE cycle between bursts.

Reset
REQ-027 While rst_n=0, the block SHALL force: state IDLE, rr_ptr 0, owner 0, idle counter 0, busy 0, abort 0; ack and fifo_wr SHALL therefore be 0 immediately, with no wait for a clock edge.
REQ-028 Reset asserted mid-burst SHALL discard the burst; no further ack is issued until a new arbitration completes after release.
REQ-029 Deassertion of rst_n SHALL take effect at the first rising clk edge after release; the block makes no synchronisation of its own.

Structure
REQ-030 The state encoding and the default TIMEOUT constant SHALL reside in the shared fifo package used by the fifo element modules.
REQ-031 The round-robin select SHALL be implemented as one sub-module, rr_pick (inputs: req, ptr; outputs: idx, any), and reused by future arbiters.

Verification
REQ-032 Single burst: req[2]=1 for 3 words, last on word 3 -> ack[2] in cycles 2,3,4 after req; fifo_data matches words 1..3; busy drops after cycle 4; rr_ptr=3.
REQ-033 Round-robin: req=4'b1111 held, each burst 1 word with last=1 -> grant order 0,1,2,3,0 with one IDLE cycle between bursts.
REQ-034 Backpressure: fifo_full=1 for 10 cycles mid-burst with req[owner]=1 -> no ack, no abort; transfer resumes on the cycle after fifo_full falls.
REQ-035 Timeout: owner 1 drops req after 1 word, TIMEOUT=15 -> abort pulses exactly 15 cycles later; next grant goes to requester 2 if it is requesting.
REQ-036 Reset mid-burst: rst_n low for 2 cycles during a burst by owner 3 -> ack=0 and busy=0 immediately; after release with req=4'b1001, first grant goes to requester 0.
